// File: rtl/mips_mc_ctrl.sv
// rtl/mips_mc_ctrl.sv - multicycle MIPS main controller (Moore FSM), optional bne via MIPS_MC_BNE_EN
module mips_mc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_en,
  output logic       reg_write,
  output logic       iord,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_control,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t r_state;
  state_t w_cur;
  logic   w_legal;
  logic   w_branch_take;

`ifdef MIPS_MC_BNE_EN
  logic [5:0] r_op;
  assign w_legal = (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_RTYPE) ||
                   (opcode == OP_BEQ) || (opcode == OP_ADDI) || (opcode == OP_J) ||
                   (opcode == OP_BNE);
  assign w_branch_take = (r_op == OP_BNE) ? ~zero : zero;
`else
  assign w_legal = (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_RTYPE) ||
                   (opcode == OP_BEQ) || (opcode == OP_ADDI) || (opcode == OP_J);
  assign w_branch_take = zero;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:   r_state <= mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_RTYPE:     r_state <= S_EXECUTE;
            OP_BEQ:       r_state <= S_BRANCH;
            OP_ADDI:      r_state <= S_ADDIEX;
            OP_J:         r_state <= S_JUMP;
`ifdef MIPS_MC_BNE_EN
            OP_BNE:       r_state <= S_BRANCH;
`endif
            default:      r_state <= S_FETCH;
          endcase
        end
        S_MEMADR:  r_state <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:   r_state <= mem_ready ? S_MEMWB : S_MEMRD;
        S_MEMWB:   r_state <= S_FETCH;
        S_MEMWR:   r_state <= mem_ready ? S_FETCH : S_MEMWR;
        S_EXECUTE: r_state <= S_ALUWB;
        S_ALUWB:   r_state <= S_FETCH;
        S_BRANCH:  r_state <= S_FETCH;
        S_ADDIEX:  r_state <= S_ADDIWB;
        S_ADDIWB:  r_state <= S_FETCH;
        S_JUMP:    r_state <= S_FETCH;
        default:   r_state <= S_FETCH;
      endcase
    end
  end

`ifdef MIPS_MC_BNE_EN
  // Branch polarity comes from the opcode seen in DECODE, not the live IR bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op <= 6'd0;
    end else if (r_state == S_DECODE) begin
      r_op <= opcode;
    end
  end
`endif

  // During reset the mux outputs already present FETCH values.
  assign w_cur = rst ? S_FETCH : r_state;
  assign state = r_state;

  always_comb begin
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    pc_en       = 1'b0;
    reg_write   = 1'b0;
    iord        = 1'b0;
    mem_to_reg  = 1'b0;
    reg_dst     = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_src      = 2'b00;
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (w_cur)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        illegal   = ~w_legal;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        case (funct)
          6'b100010: alu_control = ALU_SUB;
          6'b100100: alu_control = ALU_AND;
          6'b100101: alu_control = ALU_OR;
          6'b101010: alu_control = ALU_SLT;
          default:   alu_control = ALU_ADD;
        endcase
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        pc_en       = w_branch_take;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
      end
      S_JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      mem_req   = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_en     = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb/tb_mips_mc_ctrl.sv - scoreboard bench for mips_mc_ctrl, per-cycle output checks
module tb_mips_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, ir_write, pc_en, reg_write, iord;
  logic       mem_to_reg, reg_dst, alu_src_a, illegal;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic [3:0] state;

`ifdef MIPS_MC_BNE_EN
  localparam bit BNE = 1'b1;
`else
  localparam bit BNE = 1'b0;
`endif

  mips_mc_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .ir_write(ir_write), .pc_en(pc_en), .reg_write(reg_write), .iord(iord),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_control(alu_control),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic [20:0] exp;
    string       tag;
  } step_t;

  step_t sbq[$];
  int total = 0;
  int bad   = 0;
  logic [20:0] obs;

  assign obs = {state, mem_req, mem_write, ir_write, pc_en, reg_write, iord,
                mem_to_reg, reg_dst, alu_src_a, alu_src_b, pc_src, alu_control, illegal};

  // Reference outputs for one cycle, written from the state table.
  function automatic logic [20:0] ev(logic [3:0] st, logic rdy, logic z,
                                     logic [5:0] fn, logic [5:0] op);
    logic mr, mw, irw, pce, rw, io, m2r, rd, sa, ill;
    logic [1:0] sb, ps;
    logic [2:0] ac;
    {mr, mw, irw, pce, rw, io, m2r, rd, sa, ill} = 10'd0;
    sb = 2'b00; ps = 2'b00; ac = 3'b010;
    case (st)
      4'd0:  begin mr = 1; sb = 2'b01; irw = rdy; pce = rdy; end
      4'd1:  begin
        sb  = 2'b11;
        ill = !((op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010})
                || (BNE && op == 6'b000101));
      end
      4'd2:  begin sa = 1; sb = 2'b10; end
      4'd3:  begin mr = 1; io = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mr = 1; io = 1; mw = 1; end
      4'd6:  begin
        sa = 1;
        case (fn)
          6'b100010: ac = 3'b110;
          6'b100100: ac = 3'b000;
          6'b100101: ac = 3'b001;
          6'b101010: ac = 3'b111;
          default:   ac = 3'b010;
        endcase
      end
      4'd7:  begin rw = 1; rd = 1; end
      4'd8:  begin sa = 1; ac = 3'b110; ps = 2'b01; pce = (BNE && op == 6'b000101) ? ~z : z; end
      4'd9:  begin sa = 1; sb = 2'b10; end
      4'd10: begin rw = 1; end
      4'd11: begin ps = 2'b10; pce = 1; end
      default: ;
    endcase
    return {st, mr, mw, irw, pce, rw, io, m2r, rd, sa, sb, ps, ac, ill};
  endfunction

  task automatic push(input logic [3:0] st, input logic rdy, input logic [5:0] op,
                      input logic [5:0] fn, input logic z, input string tag);
    step_t s;
    s.rdy = rdy; s.op = op; s.fn = fn; s.z = z; s.tag = tag;
    s.exp = ev(st, rdy, z, fn, op);
    sbq.push_back(s);
  endtask

  // Expected cycle-by-cycle walk of one instruction; non-memory states get random mem_ready.
  task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int fw, input int mw, input string tag);
    logic r;
    for (int i = 0; i < fw; i++) push(4'd0, 1'b0, op, fn, z, tag);
    push(4'd0, 1'b1, op, fn, z, tag);
    r = 1'($urandom_range(0, 1));
    push(4'd1, r, op, fn, z, tag);
    case (op)
      6'b100011: begin
        push(4'd2, 1'($urandom_range(0, 1)), op, fn, z, tag);
        for (int i = 0; i < mw; i++) push(4'd3, 1'b0, op, fn, z, tag);
        push(4'd3, 1'b1, op, fn, z, tag);
        push(4'd4, 1'($urandom_range(0, 1)), op, fn, z, tag);
      end
      6'b101011: begin
        push(4'd2, 1'($urandom_range(0, 1)), op, fn, z, tag);
        for (int i = 0; i < mw; i++) push(4'd5, 1'b0, op, fn, z, tag);
        push(4'd5, 1'b1, op, fn, z, tag);
      end
      6'b000000: begin
        push(4'd6, 1'($urandom_range(0, 1)), op, fn, z, tag);
        push(4'd7, 1'($urandom_range(0, 1)), op, fn, z, tag);
      end
      6'b000100: push(4'd8, 1'($urandom_range(0, 1)), op, fn, z, tag);
      6'b001000: begin
        push(4'd9, 1'($urandom_range(0, 1)), op, fn, z, tag);
        push(4'd10, 1'($urandom_range(0, 1)), op, fn, z, tag);
      end
      6'b000010: push(4'd11, 1'($urandom_range(0, 1)), op, fn, z, tag);
      6'b000101: if (BNE) push(4'd8, 1'($urandom_range(0, 1)), op, fn, z, tag);
      default: ;
    endcase
  endtask

  task automatic run_n(input int n);
    step_t s;
    for (int i = 0; i < n && sbq.size() > 0; i++) begin
      s = sbq.pop_front();
      mem_ready = s.rdy; opcode = s.op; funct = s.fn; zero = s.z;
      @(negedge clk);
      total++;
      assert (obs === s.exp) else begin
        bad++;
        $error("FAIL %s obs=%h exp=%h", s.tag, obs, s.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    run_n(sbq.size());
  endtask

  localparam logic [16:0] RST_OUT = 17'b0_0000_0000_01_00_010_0;

  initial begin
    rst = 1'b1; mem_ready = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    assert (obs === {4'd0, RST_OUT}) else begin
      bad++; $error("FAIL reset_init obs=%h exp=%h", obs, {4'd0, RST_OUT});
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // lw abandoned in MEMRD by a 3-cycle reset, mem_ready high throughout
    push_instr(6'b100011, 6'd0, 1'b0, 0, 3, "lw_pre_reset");
    run_n(4);
    sbq.delete();
    rst = 1'b1; mem_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      assert (obs[16:0] === RST_OUT) else begin
        bad++; $error("FAIL reset_strobes c=%0d obs=%h exp=%h", c, obs[16:0], RST_OUT);
      end
      if (c > 0) begin
        total++;
        assert (state === 4'd0) else begin
          bad++; $error("FAIL reset_state c=%0d obs=%0d exp=0", c, state);
        end
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;

    // lw with 2 fetch waits and 3 read waits: 10 cycles
    push_instr(6'b100011, 6'd0, 1'b0, 2, 3, "lw_wait");
    drain();

    push_instr(6'b000000, 6'b100000, 1'b0, 0, 0, "r_add");
    push_instr(6'b000000, 6'b100010, 1'b1, 0, 0, "r_sub");
    push_instr(6'b000000, 6'b100100, 1'b0, 0, 0, "r_and");
    push_instr(6'b000000, 6'b100101, 1'b0, 0, 0, "r_or");
    push_instr(6'b000000, 6'b101010, 1'b0, 0, 0, "r_slt");
    push_instr(6'b000000, 6'b111111, 1'b0, 0, 0, "r_unknown_fn");
    drain();

    push_instr(6'b000100, 6'd0, 1'b1, 0, 0, "beq_taken");
    push_instr(6'b000100, 6'd0, 1'b0, 0, 0, "beq_not_taken");
    push_instr(6'b111111, 6'd0, 1'b0, 0, 0, "illegal_3f");
    push_instr(6'b000101, 6'd0, 1'b0, 0, 0, "bne_z0");
    push_instr(6'b000101, 6'd0, 1'b1, 0, 0, "bne_z1");
    drain();

    push_instr(6'b101011, 6'd0, 1'b0, 0, 0, "sw");
    push_instr(6'b000010, 6'd0, 1'b0, 0, 0, "j");
    push_instr(6'b101011, 6'd0, 1'b0, 1, 2, "sw_wait");
    push_instr(6'b001000, 6'd0, 1'b0, 0, 0, "addi");
    push_instr(6'b100011, 6'd0, 1'b0, 0, 0, "lw");
    drain();

    mem_ready = 1'b0;
    @(negedge clk);
    total++;
    assert (state === 4'd0) else begin
      bad++; $error("FAIL final_state obs=%0d exp=0", state);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multicycle main controller for the MIPS core: a Moore state machine that sequences the shared datapath (one memory port, one ALU, register file, PC/IR registers) through fetch, decode, execute, memory and write-back steps for each instruction. Sits inside `mips_top` between the instruction register/ALU flags and the datapath enables and muxes. Memory accesses use a ready handshake so the core works with single-cycle or wait-stated memory.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  6  IR[31:26].
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU zero flag, current cycle.
- `mem_ready`  in  1  memory completes the access requested this cycle.
- `mem_req`  out  1  memory access requested.
- `mem_write`  out  1  write strobe for the memory port.
- `ir_write`  out  1  load IR from memory read data.
- `pc_en`  out  1  PC load enable.
- `reg_write`  out  1  register file write enable.
- `iord`  out  1  0 = address from PC, 1 = from ALUOut.
- `mem_to_reg`  out  1  write-back source: 1 = data register, 0 = ALUOut.
- `reg_dst`  out  1  1 = rd, 0 = rt.
- `alu_src_a`  out  1  0 = PC, 1 = register A.
- `alu_src_b`  out  2  00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- `pc_src`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alu_control`  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- `illegal`  out  1  one-cycle pulse on unsupported opcode.
- `state`  out  4  current state encoding (debug).

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Encodings 12–15 are unused and go to FETCH.
- FETCH: `mem_req`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, add, `pc_src`=00. Holds until `mem_ready`; `ir_write` and `pc_en` are asserted only in the `mem_ready` cycle. Then DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, add. Dispatch on `opcode`:
  - lw (100011) / sw (101011) → MEMADR
  - R-type (000000) → EXECUTE
  - beq (000100) → BRANCH
  - addi (001000) → ADDIEX
  - j (000010) → JUMP
  - anything else → FETCH with `illegal`=1 for that cycle.
- MEMADR: `alu_src_a`=1, `alu_src_b`=10, add. lw → MEMRD; sw → MEMWR.
- MEMRD: `mem_req`=1, `iord`=1. Holds until `mem_ready`, then MEMWB.
- MEMWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1. Then FETCH.
- MEMWR: `mem_req`=1, `iord`=1, `mem_write`=1 while waiting. Holds until `mem_ready`, then FETCH.
- EXECUTE: `alu_src_a`=1, `alu_src_b`=00, function decode. Then ALUWB.
- ALUWB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Then FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, sub, `pc_src`=01, `pc_en`=`zero`. Then FETCH.
- ADDIEX: `alu_src_a`=1, `alu_src_b`=10, add. Then ADDIWB.
- ADDIWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Then FETCH.
- JUMP: `pc_src`=10, `pc_en`=1. Then FETCH.
- Function decode, EXECUTE only:
  - `funct` 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Any other `funct` gives add.
- Outputs not listed for a state are 0; `alu_control` defaults to add.

## Timing
- Reset: `state` = FETCH on the first edge with `rst`=1. While `rst`=1, `mem_req`, `mem_write`, `ir_write`, `pc_en`, `reg_write` and `illegal` are forced to 0. All other outputs show FETCH values.
- Reset mid-instruction: abandons the instruction with no further strobes; the next cycle after release is FETCH.
- Cycle counts with `mem_ready` tied to 1:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
  - Each wait cycle adds 1 cycle in FETCH, MEMRD or MEMWR.
- `mem_ready` is sampled only while `mem_req`=1 and is ignored otherwise.
- Outputs are combinational from `state`, plus `mem_ready`/`zero` gating. There is no output register.

## Configuration
- `MIPS_MC_BNE_EN` defined:
  - Opcode 000101 (bne) dispatches to BRANCH.
  - In BRANCH, `pc_en` = `~zero` for bne and `zero` for beq; the opcode is held in a registered copy captured in DECODE.
- Macro undefined: 000101 is illegal (→ FETCH, `illegal` pulse).

## Test plan
- Reset held 3 cycles, mid-lw in MEMRD → no strobes during reset; `state`=0 after release; next `ir_write` comes after `mem_ready`.
- R-type sequence with `mem_ready`=1 (add, sub, and, or, slt funct) → states 0,1,6,7; `alu_control` in EXECUTE = 010, 110, 000, 001, 111; `reg_write`=1 only in ALUWB.
- lw with `mem_ready` low for 2 cycles in FETCH and 3 in MEMRD → 10 cycles total; `ir_write` and `pc_en` pulse exactly once; `mem_write` never high.
- beq with `zero`=1, then `zero`=0 → `pc_en`=1 with `pc_src`=01 in state 8 for the first, `pc_en`=0 for the second; each takes 3 cycles.
- Opcode 111111 → `illegal` high for 1 cycle in DECODE, then FETCH. With `MIPS_MC_BNE_EN` defined, opcode 000101 with `zero`=0 → `pc_en`=1 in BRANCH.
- sw then j → sw asserts `mem_write` only in MEMWR; j asserts `pc_en`=1 with `pc_src`=10 in state 11.
